// File: rtl/scoreboard_pkg.sv
// Shared types and sizing for the issue/commit scoreboard.
package scoreboard_pkg;

    localparam int unsigned NR_SB_ENTRIES = 4;
    localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
    localparam int unsigned NR_WB_PORTS   = 3;

    typedef enum logic [2:0] {
        FU_NONE,
        FU_ALU,
        FU_BRANCH,
        FU_LOAD,
        FU_STORE,
        FU_MULT,
        FU_CSR
    } fu_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        logic [7:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;   // immediate at issue, result after writeback
        logic                     valid;    // result has been written back
        logic                     use_imm;
        exception                 ex;
    } scoreboard_entry;

    typedef struct packed {
        logic [63:0] data;
        logic        valid;
        logic        busy;
    } sb_lookup_t;

endpackage

// File: rtl/scoreboard_lookup.sv
// Operand lookup: finds the youngest occupied entry writing register rs_i.
module scoreboard_lookup
    import scoreboard_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = NR_SB_ENTRIES
) (
    input  scoreboard_entry          entries_i [NR_ENTRIES-1:0],
    input  logic [NR_ENTRIES-1:0]    occupied_i,
    input  logic [TRANS_ID_BITS-1:0] tail_i,
    input  logic [4:0]               rs_i,
    output sb_lookup_t               lookup_o
);

    logic [TRANS_ID_BITS-1:0] idx;

    // Walk from oldest (tail-NR_ENTRIES) to youngest (tail-1); a later hit overrides an earlier one.
    always_comb begin
        lookup_o = '0;
        idx      = '0;
        for (int k = NR_ENTRIES - 1; k >= 0; k--) begin
            idx = tail_i - TRANS_ID_BITS'(k + 1);
            if (occupied_i[idx] && (entries_i[idx].rd == rs_i) && (rs_i != 5'd0)) begin
                lookup_o.valid = entries_i[idx].valid;
                lookup_o.busy  = ~entries_i[idx].valid;
                lookup_o.data  = entries_i[idx].valid ? entries_i[idx].result : 64'd0;
            end
        end
    end

endmodule

// File: rtl/scoreboard.sv
// In-order circular scoreboard between issue and commit with writeback
// collection and rs1/rs2 forwarding lookup.
module scoreboard
    import scoreboard_pkg::*;
#(
    parameter int unsigned NR_ENTRIES  = NR_SB_ENTRIES,
    parameter int unsigned NR_WB_PORTS = scoreboard_pkg::NR_WB_PORTS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  scoreboard_entry          decoded_instr_i,
    input  logic                     decoded_instr_valid_i,
    output logic                     issue_ack_o,
    output logic [TRANS_ID_BITS-1:0] issue_trans_id_o,
    output logic                     full_o,
    input  logic [NR_WB_PORTS-1:0]   wb_valid_i,
    input  logic [TRANS_ID_BITS-1:0] wb_trans_id_i [NR_WB_PORTS-1:0],
    input  logic [63:0]              wb_data_i [NR_WB_PORTS-1:0],
    input  exception                 wb_ex_i [NR_WB_PORTS-1:0],
    output scoreboard_entry          commit_instr_o,
    output logic                     commit_valid_o,
    input  logic                     commit_ack_i,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    output logic [63:0]              rs1_o,
    output logic [63:0]              rs2_o,
    output logic                     rs1_valid_o,
    output logic                     rs2_valid_o,
    output logic                     rs1_busy_o,
    output logic                     rs2_busy_o
);

    scoreboard_entry          entries_q [NR_ENTRIES-1:0];
    logic [NR_ENTRIES-1:0]    occupied_q;
    logic [TRANS_ID_BITS-1:0] head_q, head_d;
    logic [TRANS_ID_BITS-1:0] tail_q, tail_d;
    logic [TRANS_ID_BITS:0]   count_q, count_d;
    logic                     commit_fire;
    scoreboard_entry          issue_entry;
    sb_lookup_t               rs1_lookup, rs2_lookup;

    assign full_o           = (count_q == (TRANS_ID_BITS + 1)'(NR_ENTRIES));
    assign issue_ack_o      = decoded_instr_valid_i & ~full_o & ~flush_i;
    assign issue_trans_id_o = tail_q;
    assign commit_valid_o   = occupied_q[head_q];
    assign commit_instr_o   = entries_q[head_q];
    assign commit_fire      = commit_ack_i & commit_valid_o;

    // Issued record: tagged with its slot, result/exception not yet produced.
    always_comb begin
        issue_entry          = decoded_instr_i;
        issue_entry.trans_id = tail_q;
        issue_entry.valid    = 1'b0;
        issue_entry.ex.valid = 1'b0;
    end

    // Pointer and occupancy arithmetic; a full buffer never issues, so no slot reuse within a cycle.
    always_comb begin
        head_d  = head_q + TRANS_ID_BITS'(commit_fire);
        tail_d  = tail_q + TRANS_ID_BITS'(issue_ack_o);
        count_d = count_q + (TRANS_ID_BITS + 1)'(issue_ack_o) - (TRANS_ID_BITS + 1)'(commit_fire);
    end

    // Storage update: reset, then flush, then writeback/issue/commit in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            occupied_q <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else if (flush_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            occupied_q <= '0;
        end else begin
            // Ascending port order lets the highest port index win on a collision.
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (wb_valid_i[p] && occupied_q[wb_trans_id_i[p]]) begin
                    entries_q[wb_trans_id_i[p]].result <= wb_data_i[p];
                    entries_q[wb_trans_id_i[p]].ex     <= wb_ex_i[p];
                    entries_q[wb_trans_id_i[p]].valid  <= 1'b1;
                end
            end
            if (issue_ack_o) begin
                entries_q[tail_q]  <= issue_entry;
                occupied_q[tail_q] <= 1'b1;
            end
            if (commit_fire) begin
                occupied_q[head_q] <= 1'b0;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    scoreboard_lookup #(
        .NR_ENTRIES (NR_ENTRIES)
    ) i_lookup_rs1 (
        .entries_i  (entries_q),
        .occupied_i (occupied_q),
        .tail_i     (tail_q),
        .rs_i       (rs1_i),
        .lookup_o   (rs1_lookup)
    );

    scoreboard_lookup #(
        .NR_ENTRIES (NR_ENTRIES)
    ) i_lookup_rs2 (
        .entries_i  (entries_q),
        .occupied_i (occupied_q),
        .tail_i     (tail_q),
        .rs_i       (rs2_i),
        .lookup_o   (rs2_lookup)
    );

    assign rs1_o       = rs1_lookup.data;
    assign rs1_valid_o = rs1_lookup.valid;
    assign rs1_busy_o  = rs1_lookup.busy;
    assign rs2_o       = rs2_lookup.data;
    assign rs2_valid_o = rs2_lookup.valid;
    assign rs2_busy_o  = rs2_lookup.busy;

endmodule

// File: tb/tb_scoreboard.sv
// Testbench for scoreboard: directed vector table, hand sequences and a
// randomized phase checked against a queue-based reference model.
module tb_scoreboard;
    import scoreboard_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst, flush, dec_valid, commit_ack;
    scoreboard_entry          dec;
    logic                     issue_ack, full, commit_valid;
    logic [TRANS_ID_BITS-1:0] issue_tid;
    logic [NR_WB_PORTS-1:0]   wb_valid;
    logic [TRANS_ID_BITS-1:0] wb_id [NR_WB_PORTS-1:0];
    logic [63:0]              wb_data [NR_WB_PORTS-1:0];
    exception                 wb_ex [NR_WB_PORTS-1:0];
    scoreboard_entry          commit_instr;
    logic [4:0]               rs1, rs2;
    logic [63:0]              rs1_d, rs2_d;
    logic                     rs1_v, rs2_v, rs1_b, rs2_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scoreboard dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .flush_i               (flush),
        .decoded_instr_i       (dec),
        .decoded_instr_valid_i (dec_valid),
        .issue_ack_o           (issue_ack),
        .issue_trans_id_o      (issue_tid),
        .full_o                (full),
        .wb_valid_i            (wb_valid),
        .wb_trans_id_i         (wb_id),
        .wb_data_i             (wb_data),
        .wb_ex_i               (wb_ex),
        .commit_instr_o        (commit_instr),
        .commit_valid_o        (commit_valid),
        .commit_ack_i          (commit_ack),
        .rs1_i                 (rs1),
        .rs2_i                 (rs2),
        .rs1_o                 (rs1_d),
        .rs2_o                 (rs2_d),
        .rs1_valid_o           (rs1_v),
        .rs2_valid_o           (rs2_v),
        .rs1_busy_o            (rs1_b),
        .rs2_busy_o            (rs2_b)
    );

    // ---------------- reference model: an age-ordered queue ----------------
    scoreboard_entry          mq[$];
    logic [TRANS_ID_BITS-1:0] m_next_id = '0;

    function automatic sb_lookup_t m_lookup(input logic [4:0] rs);
        sb_lookup_t r;
        r = '0;
        if (rs != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].rd == rs) begin
                    r.valid = mq[i].valid;
                    r.busy  = !mq[i].valid;
                    r.data  = mq[i].result;
                    break;
                end
            end
        end
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit ack;
        bit cmt;
        scoreboard_entry e;
        ack = dec_valid && (mq.size() < NR_SB_ENTRIES) && !flush;
        cmt = commit_ack && (mq.size() > 0);
        if (rst || flush) begin
            mq.delete();
            m_next_id = '0;
        end else begin
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (wb_valid[p]) begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (mq[i].trans_id == wb_id[p]) begin
                            mq[i].result = wb_data[p];
                            mq[i].ex     = wb_ex[p];
                            mq[i].valid  = 1'b1;
                        end
                    end
                end
            end
            if (cmt) begin
                e = mq.pop_front();
                $display("commit id=%0d rd=%0d valid=%0b", e.trans_id, e.rd, e.valid);
            end
            if (ack) begin
                e          = dec;
                e.trans_id = m_next_id;
                e.valid    = 1'b0;
                e.ex.valid = 1'b0;
                mq.push_back(e);
                m_next_id  = m_next_id + 1'b1;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Data is only defined when forwarding is usable or there is no producer at all.
    task automatic chk_lookup(input string nm, input logic v, input logic b, input logic [63:0] d,
                              input logic ev, input logic eb, input logic [63:0] ed);
        chk({nm, "_valid"}, 320'(v), 320'(ev));
        chk({nm, "_busy"}, 320'(b), 320'(eb));
        if (ev || !eb) chk({nm, "_data"}, 320'(d), 320'(ed));
    endtask

    task automatic finish_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst        = 1'b0;
        flush      = 1'b0;
        dec        = '0;
        dec_valid  = 1'b0;
        commit_ack = 1'b0;
        wb_valid   = '0;
        rs1        = '0;
        rs2        = '0;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            wb_id[p]   = '0;
            wb_data[p] = '0;
            wb_ex[p]   = '0;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic v; logic [4:0] rd; logic fl; logic ca;
        logic [2:0] wbv; logic [5:0] wbid; logic [7:0] d0, d1, d2;
        logic [4:0] r1, r2;
        logic ack; logic [1:0] tid; logic full; logic cv;
        logic r1v, r1b; logic [7:0] r1d;
        logic r2v, r2b; logic [7:0] r2d;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [4:0] rd, input logic fl, input logic ca,
                                input logic [2:0] wbv, input logic [5:0] wbid,
                                input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic ack, input logic [1:0] tid, input logic fu, input logic cv,
                                input logic r1v, input logic r1b, input logic [7:0] r1d,
                                input logic r2v, input logic r2b, input logic [7:0] r2d);
        vec_t t;
        t.v = v; t.rd = rd; t.fl = fl; t.ca = ca; t.wbv = wbv; t.wbid = wbid;
        t.d0 = d0; t.d1 = d1; t.d2 = d2; t.r1 = r1; t.r2 = r2;
        t.ack = ack; t.tid = tid; t.full = fu; t.cv = cv;
        t.r1v = r1v; t.r1b = r1b; t.r1d = r1d; t.r2v = r2v; t.r2b = r2b; t.r2d = r2d;
        return t;
    endfunction

    task automatic apply_vec(input vec_t t, input int idx);
        clear_inputs();
        dec_valid      = t.v;
        dec.pc         = 64'h8000_0000 + 64'(idx * 4);
        dec.rd         = t.rd;
        dec.result     = 64'h1000 + 64'(t.rd);
        dec.trans_id   = 2'd3;
        dec.valid      = 1'b1;
        dec.ex.valid   = 1'b1;
        flush          = t.fl;
        commit_ack     = t.ca;
        wb_valid       = t.wbv;
        for (int p = 0; p < NR_WB_PORTS; p++) wb_id[p] = t.wbid[2*p +: 2];
        wb_data[0] = 64'(t.d0);
        wb_data[1] = 64'(t.d1);
        wb_data[2] = 64'(t.d2);
        rs1 = t.r1;
        rs2 = t.r2;
        @(negedge clk);
        chk($sformatf("v%0d_ack", idx), 320'(issue_ack), 320'(t.ack));
        chk($sformatf("v%0d_tid", idx), 320'(issue_tid), 320'(t.tid));
        chk($sformatf("v%0d_full", idx), 320'(full), 320'(t.full));
        chk($sformatf("v%0d_cvalid", idx), 320'(commit_valid), 320'(t.cv));
        chk_lookup($sformatf("v%0d_rs1", idx), rs1_v, rs1_b, rs1_d, t.r1v, t.r1b, 64'(t.r1d));
        chk_lookup($sformatf("v%0d_rs2", idx), rs2_v, rs2_b, rs2_d, t.r2v, t.r2b, 64'(t.r2d));
        $display("vec %0d: ack=%0b tid=%0d full=%0b cv=%0b rs1 v/b=%0b%0b rs2 v/b=%0b%0b",
                 idx, issue_ack, issue_tid, full, commit_valid, rs1_v, rs1_b, rs2_v, rs2_b);
        finish_cycle();
    endtask

    vec_t tv [22];
    sb_lookup_t ml1, ml2;

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // reset state
        @(negedge clk);
        chk("rst_full", 320'(full), 320'(0));
        chk("rst_cvalid", 320'(commit_valid), 320'(0));
        chk("rst_cinstr", 320'(commit_instr), 320'(0));
        chk("rst_tid", 320'(issue_tid), 320'(0));
        finish_cycle();
        rst = 1'b0;

        //            v rd fl ca wbv    wbid   d0     d1     d2     r1 r2  ack tid fu cv  r1v r1b r1d    r2v r2b r2d
        tv[0]  = mk(1, 1, 0, 0, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 1, 0,  1, 0, 0, 0,  0, 0, 8'h00, 0, 0, 8'h00);
        tv[1]  = mk(1, 2, 0, 0, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 1, 2,  1, 1, 0, 1,  0, 1, 8'h00, 0, 0, 8'h00);
        tv[2]  = mk(1, 3, 0, 0, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 2, 0,  1, 2, 0, 1,  0, 1, 8'h00, 0, 0, 8'h00);
        tv[3]  = mk(1, 4, 0, 0, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 3, 4,  1, 3, 0, 1,  0, 1, 8'h00, 0, 0, 8'h00);
        tv[4]  = mk(1, 6, 0, 0, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 0, 4,  0, 0, 1, 1,  0, 0, 8'h00, 0, 1, 8'h00);
        tv[5]  = mk(0, 0, 0, 0, 3'b101, 6'h22, 8'hAA, 8'h00, 8'hBB, 3, 0,  0, 0, 1, 1,  0, 1, 8'h00, 0, 0, 8'h00);
        tv[6]  = mk(0, 0, 0, 0, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 3, 1,  0, 0, 1, 1,  1, 0, 8'hBB, 0, 1, 8'h00);
        tv[7]  = mk(0, 0, 1, 0, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 3, 0,  0, 0, 1, 1,  1, 0, 8'hBB, 0, 0, 8'h00);
        tv[8]  = mk(1, 5, 0, 0, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 3, 0,  1, 0, 0, 0,  0, 0, 8'h00, 0, 0, 8'h00);
        tv[9]  = mk(1, 7, 0, 0, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 5, 0,  1, 1, 0, 1,  0, 1, 8'h00, 0, 0, 8'h00);
        tv[10] = mk(1, 5, 0, 0, 3'b010, 6'h00, 8'h00, 8'h11, 8'h00, 0, 5,  1, 2, 0, 1,  0, 0, 8'h00, 0, 1, 8'h00);
        tv[11] = mk(0, 0, 0, 0, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 5, 5,  0, 3, 0, 1,  0, 1, 8'h00, 0, 1, 8'h00);
        tv[12] = mk(0, 0, 0, 0, 3'b001, 6'h02, 8'h07, 8'h00, 8'h00, 7, 5,  0, 3, 0, 1,  0, 1, 8'h00, 0, 1, 8'h00);
        tv[13] = mk(0, 0, 0, 0, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 7, 5,  0, 3, 0, 1,  0, 1, 8'h00, 1, 0, 8'h07);
        tv[14] = mk(1, 8, 0, 0, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 8, 5,  1, 3, 0, 1,  0, 0, 8'h00, 1, 0, 8'h07);
        tv[15] = mk(1, 9, 0, 1, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 8, 0,  0, 0, 1, 1,  0, 1, 8'h00, 0, 0, 8'h00);
        tv[16] = mk(1, 9, 0, 0, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 9, 5,  1, 0, 0, 1,  0, 0, 8'h00, 1, 0, 8'h07);
        tv[17] = mk(0, 0, 0, 0, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 9, 5,  0, 1, 1, 1,  0, 1, 8'h00, 1, 0, 8'h07);
        tv[18] = mk(0, 0, 0, 1, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 7, 0,  0, 1, 1, 1,  0, 1, 8'h00, 0, 0, 8'h00);
        tv[19] = mk(0, 0, 0, 1, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 7, 0,  0, 1, 0, 1,  0, 0, 8'h00, 0, 0, 8'h00);
        tv[20] = mk(1, 3, 1, 0, 3'b001, 6'h00, 8'h55, 8'h00, 8'h00, 9, 5,  0, 1, 0, 1,  0, 1, 8'h00, 0, 0, 8'h00);
        tv[21] = mk(0, 0, 0, 0, 3'b000, 6'h00, 8'h00, 8'h00, 8'h00, 9, 5,  0, 0, 0, 0,  0, 0, 8'h00, 0, 0, 8'h00);
        for (int i = 0; i < 22; i++) apply_vec(tv[i], i);

        // Reset in the middle of operation with three entries occupied.
        clear_inputs();
        for (int i = 1; i <= 3; i++) begin
            dec       = '0;
            dec.rd    = 5'(i);
            dec_valid = 1'b1;
            @(negedge clk);
            finish_cycle();
        end
        rst        = 1'b1;
        dec_valid  = 1'b1;
        commit_ack = 1'b1;
        wb_valid   = '1;
        rs1        = 5'd1;
        rs2        = 5'd2;
        @(negedge clk);
        finish_cycle();
        clear_inputs();
        rs1 = 5'd1;
        rs2 = 5'd2;
        @(negedge clk);
        chk("mrst_full", 320'(full), 320'(0));
        chk("mrst_cvalid", 320'(commit_valid), 320'(0));
        chk("mrst_cinstr", 320'(commit_instr), 320'(0));
        chk("mrst_ack", 320'(issue_ack), 320'(0));
        chk("mrst_tid", 320'(issue_tid), 320'(0));
        chk_lookup("mrst_rs1", rs1_v, rs1_b, rs1_d, 1'b0, 1'b0, 64'd0);
        chk_lookup("mrst_rs2", rs2_v, rs2_b, rs2_d, 1'b0, 1'b0, 64'd0);
        $display("mid-run reset: full=%0b cv=%0b tid=%0d", full, commit_valid, issue_tid);
        finish_cycle();

        // An entry with rd=0 must never be forwarded.
        dec        = '0;
        dec.rd     = 5'd0;
        dec.result = 64'h1234;
        dec_valid  = 1'b1;
        @(negedge clk);
        finish_cycle();
        clear_inputs();
        wb_valid   = 3'b001;
        wb_data[0] = 64'd99;
        @(negedge clk);
        finish_cycle();
        clear_inputs();
        @(negedge clk);
        chk_lookup("x0_rs1", rs1_v, rs1_b, rs1_d, 1'b0, 1'b0, 64'd0);
        chk_lookup("x0_rs2", rs2_v, rs2_b, rs2_d, 1'b0, 1'b0, 64'd0);
        chk("x0_cvalid", 320'(commit_valid), 320'(1));
        chk("x0_cresult", 320'(commit_instr.result), 320'(99));
        $display("rd=0 entry: rs1 v/b=%0b%0b result=%0d", rs1_v, rs1_b, commit_instr.result);
        finish_cycle();

        // Randomized phase against the queue model.
        rst = 1'b1;
        @(negedge clk);
        finish_cycle();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            clear_inputs();
            rst          = ($urandom_range(0, 199) == 0);
            flush        = ($urandom_range(0, 49) == 0);
            dec_valid    = ($urandom_range(0, 2) != 0);
            dec.pc       = {$urandom, $urandom};
            dec.trans_id = 2'($urandom);
            dec.fu       = fu_t'($urandom_range(0, 6));
            dec.op       = 8'($urandom);
            dec.rs1      = 5'($urandom);
            dec.rs2      = 5'($urandom);
            dec.rd       = 5'($urandom_range(0, 7));
            dec.result   = {$urandom, $urandom};
            dec.valid    = 1'($urandom);
            dec.use_imm  = 1'($urandom);
            dec.ex       = {$urandom, $urandom, $urandom, $urandom, 1'($urandom)};
            commit_ack   = 1'($urandom);
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                wb_valid[p] = ($urandom_range(0, 2) == 0);
                wb_id[p]    = 2'($urandom);
                wb_data[p]  = {$urandom, $urandom};
                wb_ex[p]    = {$urandom, $urandom, $urandom, $urandom, 1'($urandom)};
            end
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            @(negedge clk);
            ml1 = m_lookup(rs1);
            ml2 = m_lookup(rs2);
            chk("r_ack", 320'(issue_ack),
                320'(dec_valid && (mq.size() < NR_SB_ENTRIES) && !flush));
            chk("r_tid", 320'(issue_tid), 320'(m_next_id));
            chk("r_full", 320'(full), 320'(mq.size() == NR_SB_ENTRIES));
            chk("r_cvalid", 320'(commit_valid), 320'(mq.size() > 0));
            if (mq.size() > 0) chk("r_cinstr", 320'(commit_instr), 320'(mq[0]));
            chk_lookup("r_rs1", rs1_v, rs1_b, rs1_d, ml1.valid, ml1.busy, ml1.data);
            chk_lookup("r_rs2", rs2_v, rs2_b, rs2_d, ml2.valid, ml2.busy, ml2.data);
            finish_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scoreboard.md
Name: scoreboard

Overview:
- Circular in-order buffer of `scoreboard_entry` records between the decode/issue stage and the commit stage.
- Assigns a `trans_id` to each issued instruction and collects results and exceptions from the functional-unit writeback ports.
- Offers the oldest entry to commit.
- Provides operand lookup for rs1/rs2: forwarded value, or a busy indication for RAW hazards.

Parameters:
- NR_ENTRIES, default NR_SB_ENTRIES (4): number of entries; power of two; trans_id width is TRANS_ID_BITS.
- NR_WB_PORTS, default NR_WB_PORTS (3): number of writeback ports.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- flush_i  in  1  discard all entries
- decoded_instr_i  in  scoreboard_entry  instruction to issue; its trans_id, valid and ex.valid fields are ignored
- decoded_instr_valid_i  in  1  issue request
- issue_ack_o  out  1  entry accepted this cycle
- issue_trans_id_o  out  TRANS_ID_BITS  trans_id given to the entry being issued
- full_o  out  1  all entries occupied
- wb_valid_i  in  NR_WB_PORTS  per-port writeback strobe
- wb_trans_id_i  in  NR_WB_PORTS x TRANS_ID_BITS  target entry per port
- wb_data_i  in  NR_WB_PORTS x 64  result per port
- wb_ex_i  in  NR_WB_PORTS x exception  exception per port
- commit_instr_o  out  scoreboard_entry  oldest entry
- commit_valid_o  out  1  oldest entry is occupied
- commit_ack_i  in  1  commit consumes the oldest entry
- rs1_i, rs2_i  in  5  source registers to look up
- rs1_o, rs2_o  out  64  forwarded result
- rs1_valid_o, rs2_valid_o  out  1  forwarded result is usable
- rs1_busy_o, rs2_busy_o  out  1  a matching producer exists but has not written back

Behaviour:
- Reset, at posedge with rst_i=1:
  - head=0, tail=0, count=0.
  - All entry occupied/valid bits cleared; entry payload zeroed.
  - Resulting outputs: full_o=0, commit_valid_o=0, commit_instr_o=0, issue_ack_o=0, issue_trans_id_o=0, rs*_valid_o=0, rs*_busy_o=0, rs*_o=0.
- Storage:
  - Registered array of NR_ENTRIES entries, each with an occupied bit.
  - head/tail are TRANS_ID_BITS wide and wrap modulo NR_ENTRIES.
  - count is TRANS_ID_BITS+1 wide.
- full_o = (count==NR_ENTRIES), combinational from registers.
- Issue:
  - issue_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i (combinational).
  - issue_trans_id_o = tail.
  - On ack, at posedge: entry[tail] takes decoded_instr_i with trans_id=tail, valid=0, ex.valid=0, occupied=1; the result field holds the immediate; tail++.
  - There is no same-cycle bypass when full: a commit in the same cycle does not free a slot for issue.
- Writeback:
  - For each port with wb_valid_i set and entry[wb_trans_id_i] occupied: write result=wb_data_i, ex=wb_ex_i, valid=1.
  - Writeback to an unoccupied entry is ignored.
  - Two ports targeting the same entry in one cycle: the highest port index wins.
- Commit:
  - commit_valid_o = occupied[head]; commit_instr_o = entry[head] (registered content, no writeback bypass).
  - commit_ack_i with commit_valid_o=1: clear occupied[head], head++ at posedge.
  - commit_ack_i with commit_valid_o=0 is ignored.
  - The commit stage acks only when commit_instr_o.valid or commit_instr_o.ex.valid is set; the scoreboard does not check this.
- count update: count_next = count + issue - commit. Simultaneous issue and commit keep count unchanged.
- Flush:
  - flush_i at posedge: head=tail=count=0 and all occupied bits cleared.
  - Flush takes priority over issue, writeback and commit in the same cycle.
- Lookup (combinational, identical for rs1 and rs2):
  - Match = occupied entry with rd==rs.
  - rs==0 never matches.
  - The youngest match wins; age is measured backward from tail-1.
  - Youngest match with valid=1: rs_valid_o=1, rs_o=result, rs_busy_o=0.
  - Youngest match with valid=0: rs_busy_o=1, rs_valid_o=0.
  - No match: all lookup outputs 0.
  - A writeback in the current cycle is not visible until the next cycle.

Decomposition:
- In the shared package: NR_SB_ENTRIES, TRANS_ID_BITS, NR_WB_PORTS, and the scoreboard_entry and exception types.
- Also in the shared package: new typedef sb_lookup_t {logic [63:0] data; logic valid; logic busy}.
- Sub-module: scoreboard_lookup performs the age-ordered youngest-match search.
  - Inputs: entry array, occupied bits, tail, rs.
  - Instantiated twice, once for rs1 and once for rs2.

Test Plan:
1. Issue four instructions with rd=1,2,3,4 and no commits. Required: trans_ids 0,1,2,3; full_o=1 after the 4th; a 5th request gives issue_ack_o=0.
2. Writeback port0 id=2 data=0xAA and port2 id=2 data=0xBB in the same cycle. Required: entry 2 result=0xBB, valid=1; lookup rs1=3 next cycle gives rs1_o=0xBB, rs1_valid_o=1.
3. Entries 0 and 2 both rd=5; entry 0 written back, entry 2 pending. Required: rs2=5 gives rs2_busy_o=1, rs2_valid_o=0; after entry 2 writes back 0x7, rs2_o=0x7, rs2_valid_o=1.
4. Full buffer with head written back; assert commit_ack_i and decoded_instr_valid_i in the same cycle. Required: commit succeeds, issue_ack_o=0, count=3; next cycle the issue gets trans_id=0 (wrap) and count=4.
5. Two entries occupied; assert flush_i together with an issue request and a writeback to id 0. Required: issue_ack_o=0; next cycle commit_valid_o=0, count=0, issue_trans_id_o=0, all lookups 0.
6. Assert rst_i mid-operation with three entries occupied. Required: next cycle every output at its reset value; rs1_i=0 always gives zero outputs.
